// File: rtl/multicycle_mem.sv
// multicycle_mem: single-port 16-bit word memory. Reads are fully pipelined and
// return LATENCY cycles after they are accepted. Writes commit on the edge that
// accepts them.
//
// Ports:
//   clk        - single clock; all state changes on the rising edge
//   rst_n      - asynchronous active-low reset (clears the pipeline and counter only)
//   enable     - request strobe; a request is accepted on every rising edge with enable=1
//   wr         - request type: 1 = write, 0 = read
//   addr       - byte address; word index = addr[DEPTH_LOG2:1]
//   data_in    - write data
//   data_out   - read data while data_valid=1, otherwise 16'h0000
//   data_valid - one-cycle pulse per accepted read
//   busy       - at least one accepted read has not yet produced data_valid
module multicycle_mem #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy
);

  localparam int unsigned Words = 2 ** DEPTH_LOG2;
  localparam int          Lat   = int'(LATENCY);

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  rd_accept;
  logic                  wr_accept;
  logic [15:0]           rd_data;

  // Only addr[DEPTH_LOG2:1] selects a word; the rest is intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^addr;

  assign word_idx  = addr[DEPTH_LOG2:1];
  // With enable=0 these collapse to 0 regardless of X on wr/addr.
  assign rd_accept = enable & ~wr;
  assign wr_accept = enable & wr & rst_n;

  // Storage starts zeroed and is never touched by reset.
  logic [15:0] mem [Words] = '{default: 16'h0000};

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[word_idx] <= data_in;
    end
  end

  // Combinational read of the pre-edge contents, so a read on the same edge as
  // a write to the same word snapshots the old value.
  assign rd_data = rd_accept ? mem[word_idx] : 16'h0000;

  // Read pipeline: stage 0 takes the snapshot, the last stage drives the outputs.
  logic [LATENCY-1:0] valid_q;
  logic [15:0]        data_q [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < Lat; i++) begin
        data_q[i] <= 16'h0000;
      end
    end else begin
      valid_q[0] <= rd_accept;
      data_q[0]  <= rd_data;
      for (int i = 1; i < Lat; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign data_valid = valid_q[LATENCY-1];
  assign data_out   = data_valid ? data_q[LATENCY-1] : 16'h0000;

  // In-flight read counter; bounded by LATENCY because every accepted read
  // retires exactly LATENCY cycles later.
  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    unique case ({rd_accept, data_valid})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy = (count_q != 4'd0);

endmodule

// File: tb/tb_multicycle_mem.sv
// tb_multicycle_mem: directed self-checking bench for multicycle_mem.
// dut uses the default LATENCY=4; dut1 shares every input and uses LATENCY=1.
// Edge numbering in comments is relative to the first request of each scenario.
module tb_multicycle_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] data_in = 16'h0000;
  logic [15:0] data_out, data_out1;
  logic        data_valid, data_valid1;
  logic        busy, busy1;

  int errors = 0;
  int checks = 0;

  logic [15:0] words [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  multicycle_mem dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy)
  );

  multicycle_mem #(.LATENCY(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out1),
    .data_valid (data_valid1),
    .busy       (busy1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Apply one request (or bubble), take one rising edge, settle 1 time unit.
  task automatic step(input logic en, input logic w, input logic [15:0] a,
                      input logic [15:0] d);
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'bx, 16'hxxxx, 16'hxxxx);
  endtask

  initial begin
    // Reset
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {15'd0, data_valid}, 16'h0000);
    check("rst_dout", data_out, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'h0000);
    rst_n = 1'b1;

    // Write BEEF at edge 0, read it at edge 1, data at edge 5
    step(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    step(1'b1, 1'b0, 16'h0010, 16'h0000);
    check("beef_busy_e1", {15'd0, busy}, 16'h0001);
    check("beef_nv_e1", {15'd0, data_valid}, 16'h0000);
    idle();
    idle();
    check("beef_busy_e3", {15'd0, busy}, 16'h0001);
    check("beef_nv_e3", {15'd0, data_valid}, 16'h0000);
    idle();
    check("beef_valid", {15'd0, data_valid}, 16'h0001);
    check("beef_data", data_out, 16'hBEEF);
    check("beef_busy_e4", {15'd0, busy}, 16'h0001);
    idle();
    check("beef_nv_e5", {15'd0, data_valid}, 16'h0000);
    check("beef_dout0_e5", data_out, 16'h0000);
    check("beef_idle_e5", {15'd0, busy}, 16'h0000);

    // Back-to-back reads of words 0..3
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'(2 * i), words[i]);
    step(1'b1, 1'b0, 16'h0000, 16'h0000);
    step(1'b1, 1'b0, 16'h0002, 16'h0000);
    step(1'b1, 1'b0, 16'h0004, 16'h0000);
    check("b2b_nv_e2", {15'd0, data_valid}, 16'h0000);
    step(1'b1, 1'b0, 16'h0006, 16'h0000);
    check("b2b_peak", {12'd0, dut.count_q}, 16'h0004);
    check("b2b_v0", {15'd0, data_valid}, 16'h0001);
    check("b2b_d0", data_out, 16'h1111);
    idle();
    check("b2b_v1", {15'd0, data_valid}, 16'h0001);
    check("b2b_d1", data_out, 16'h2222);
    check("b2b_cnt_e4", {12'd0, dut.count_q}, 16'h0003);
    idle();
    check("b2b_d2", data_out, 16'h3333);
    idle();
    check("b2b_v3", {15'd0, data_valid}, 16'h0001);
    check("b2b_d3", data_out, 16'h4444);
    idle();
    check("b2b_nv_e7", {15'd0, data_valid}, 16'h0000);
    check("b2b_idle", {15'd0, busy}, 16'h0000);

    // Read/write ordering on 0x0020
    step(1'b1, 1'b1, 16'h0020, 16'h0001);
    step(1'b1, 1'b0, 16'h0020, 16'h0000);
    step(1'b1, 1'b1, 16'h0020, 16'hCAFE);
    step(1'b1, 1'b0, 16'h0020, 16'h0000);
    idle();
    check("ord_old_v", {15'd0, data_valid}, 16'h0001);
    check("ord_old_d", data_out, 16'h0001);
    idle();
    check("ord_gap", {15'd0, data_valid}, 16'h0000);
    idle();
    check("ord_new_v", {15'd0, data_valid}, 16'h0001);
    check("ord_new_d", data_out, 16'hCAFE);
    idle();
    check("ord_idle", {15'd0, busy}, 16'h0000);

    // Odd and even byte addresses alias the same word
    step(1'b1, 1'b1, 16'h0011, 16'h5A5A);
    step(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle();
    idle();
    idle();
    check("alias_v", {15'd0, data_valid}, 16'h0001);
    check("alias_d", data_out, 16'h5A5A);

    // Reset with a read in flight; a write attempted during reset must not land
    step(1'b1, 1'b1, 16'h0040, 16'h1234);
    step(1'b1, 1'b0, 16'h0040, 16'h0000);
    idle();
    idle();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {15'd0, busy}, 16'h0000);
    check("mid_rst_valid", {15'd0, data_valid}, 16'h0000);
    check("mid_rst_dout", data_out, 16'h0000);
    step(1'b1, 1'b1, 16'h0040, 16'hFFFF);
    check("in_rst_busy", {15'd0, busy}, 16'h0000);
    check("in_rst_dout", data_out, 16'h0000);
    rst_n = 1'b1;
    idle();
    check("rst_discard_v", {15'd0, data_valid}, 16'h0000);
    check("rst_discard_b", {15'd0, busy}, 16'h0000);
    step(1'b1, 1'b0, 16'h0040, 16'h0000);
    idle();
    idle();
    idle();
    check("persist_v", {15'd0, data_valid}, 16'h0001);
    check("persist_d", data_out, 16'h1234);
    idle();

    // LATENCY=1: alternating read/idle for 20 cycles
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        step(1'b1, 1'b0, 16'(2 * ((i / 2) % 4)), 16'h0000);
        check("l1_valid", {15'd0, data_valid1}, 16'h0001);
        check("l1_data", data_out1, words[(i / 2) % 4]);
        check("l1_cnt_rd", {12'd0, dut1.count_q}, 16'h0001);
      end else begin
        idle();
        check("l1_bubble", {15'd0, data_valid1}, 16'h0000);
        check("l1_cnt_idle", {12'd0, dut1.count_q}, 16'h0000);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_mem.md
MULTICYCLE_MEM -- requirements
Module: multicycle_mem

Interface
REQ-001 Parameter LATENCY, default 4: cycles from read acceptance to data_valid; legal range 1..8.
REQ-002 Parameter DEPTH_LOG2, default 15: log2 of storage depth in 16-bit words; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  request strobe; a request is accepted on every rising edge where enable=1.
REQ-006 wr  input  1  request type: 1=write, 0=read; sampled only when enable=1.
REQ-007 addr  input  16  byte address; word index = addr[DEPTH_LOG2:1]; addr[0] and bits above DEPTH_LOG2 are ignored.
REQ-008 data_in  input  16  write data; sampled only when enable=1 and wr=1.
REQ-009 data_out  output  16  read data; valid only while data_valid=1, otherwise 16'h0000.
REQ-010 data_valid  output  1  one-cycle pulse per accepted read, LATENCY cycles after acceptance.
REQ-011 busy  output  1  high while at least one accepted read has not yet produced data_valid.

Function
REQ-012 Storage: 2^DEPTH_LOG2 words x 16 bits, all zero at time 0; rst_n does not alter contents.
REQ-013 Requests are fully pipelined, one per cycle, with no backpressure; enable is never refused.
REQ-014 Write accepted at edge N commits at edge N; it produces no data_valid pulse and does not affect busy.
REQ-015 Read accepted at edge N snapshots the word at edge N; that value is presented at edge N+LATENCY with data_valid=1 for exactly one cycle.
REQ-016 Read/write ordering: a read accepted at edge N+1 or later returns the data committed by a write at edge N; a read at edge N returns the pre-write value.
REQ-017 Pipeline: LATENCY-stage shift register of {valid, data}; stage 0 is loaded with {enable & ~wr, snapshot}; the last stage drives data_valid and data_out.
REQ-018 Back-to-back reads on consecutive edges produce data_valid on consecutive cycles, in issue order, with no gaps.
REQ-019 Outstanding count: 4-bit in-flight read counter; +1 on read accept; -1 when data_valid=1; unchanged when both occur in the same cycle; maximum value LATENCY, never wraps.
REQ-020 busy = (count != 0), combinational from the counter.
REQ-021 enable=0 inserts a bubble: stage 0 loaded with valid=0 and data 0.
REQ-022 An X on wr or addr while enable=0 has no effect on state.

Reset
REQ-023 rst_n=0 immediately clears all pipeline valid bits, stage data, and the counter: data_valid=0, data_out=16'h0000, busy=0.
REQ-024 Reads in flight when reset asserts are discarded and never produce data_valid; writes already committed persist.
REQ-025 No request is accepted on an edge where rst_n=0; the first request may be accepted on the first edge after rst_n deasserts.

Verification
REQ-026 Write addr=16'h0010 data=16'hBEEF at edge 0; read addr=16'h0010 at edge 1 -> data_valid=1, data_out=16'hBEEF at edge 5; busy high for edges 1 through 4, low after edge 5.
REQ-027 Reads of words 0,1,2,3 (pre-written 16'h1111..16'h4444) on edges 0-3 -> data_valid high at edges 4-7, data_out 16'h1111,16'h2222,16'h3333,16'h4444; count peaks at 4.
REQ-028 Read and write to addr 16'h0020 (old 16'h0001) at edges 0 and 1 respectively -> read returns 16'h0001 at edge 4; a read at edge 2 returns the new data at edge 6.
REQ-029 Read at edge 0, rst_n low between edges 2 and 3 -> no data_valid at edge 4; busy=0 and data_out=0 during reset; memory contents unchanged.
REQ-030 addr=16'h0011 and 16'h0010 -> same word; write via odd address, read via even address -> identical data.
REQ-031 Alternating read/idle for 20 cycles with LATENCY=1 -> every read produces data_valid on the next edge; count never exceeds 1.
